// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset core.
// State encodings are visible on state_dbg, so their values must stay fixed.
package mc_pkg;

    typedef enum logic [3:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/alu.sv
// 32-bit ALU: ADD/SUB/AND/ORR with NZCV flags {N,Z,C,V}.
// C is carry-out for add and NOT borrow for sub; logical ops clear C and V.
module alu
    import mc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  alu_ctrl,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [32:0] sum;
    logic        carry;
    logic        overflow;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        sum      = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                result   = sum[31:0];
                carry    = sum[32];
                overflow = (a[31] == b[31]) && (result[31] != a[31]);
            end
            ALU_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + 33'd1;
                result   = sum[31:0];
                carry    = sum[32];
                overflow = (a[31] != b[31]) && (result[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            default: result = '0;
        endcase
    end

    assign flags = {result[31], (result == 32'd0), carry, overflow};

endmodule

// File: rtl/extend.sv
// Immediate extender: rotated imm8 (data-processing), zero-extended imm12
// (load/store) and sign-extended word offset imm24 (branch).
module extend
    import mc_pkg::*;
(
    input  logic [23:0] instr,
    input  logic [1:0]  imm_src,
    output logic [31:0] ext_imm
);

    logic [4:0]  rot_amt;
    logic [63:0] rot_full;

    // Right-rotate by doubling the word and shifting; the low half is the result.
    assign rot_amt  = {instr[11:8], 1'b0};
    assign rot_full = {24'd0, instr[7:0], 24'd0, instr[7:0]} >> rot_amt;

    always_comb begin
        ext_imm = '0;
        case (imm_src)
            OP_DP:   ext_imm = rot_full[31:0];
            OP_MEM:  ext_imm = {20'd0, instr[11:0]};
            OP_BR:   ext_imm = {{6{instr[23]}}, instr[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

endmodule

// File: rtl/mc_fsm.sv
// Multicycle control FSM: state register, next-state logic, control outputs
// and the condition-code check against the registered NZCV flags.
module mc_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] flags,
    input  logic       mem_ready,
    output logic [3:0] state_dbg,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_pc,
    output logic       ir_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       alu_src_imm,
    output logic [1:0] alu_ctrl,
    output logic       flags_write,
    output logic       data_write,
    output logic       reg_write,
    output logic       reg_src_data,
    output logic       pc_write_alu,
    output logic       pc_branch
);

    state_t    state, next_state;
    logic      cond_ok, op_ok, cmd_ok;
    logic      n, z, c, v;
    logic [3:0] cmd;
    alu_ctrl_t dp_ctrl;

    assign {n, z, c, v} = flags;
    assign cmd          = funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) state <= RST;
        else       state <= next_state;
    end

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = !z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = !c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = !n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = !v;
            COND_HI: cond_ok = c && !z;
            COND_LS: cond_ok = !c || z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = !z && (n == v);
            COND_LE: cond_ok = z || (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Data-processing commands outside the subset are skipped like a failed condition.
    always_comb begin
        cmd_ok  = 1'b1;
        dp_ctrl = ALU_ADD;
        case (cmd)
            CMD_ADD: dp_ctrl = ALU_ADD;
            CMD_SUB: dp_ctrl = ALU_SUB;
            CMD_AND: dp_ctrl = ALU_AND;
            CMD_ORR: dp_ctrl = ALU_ORR;
            default: cmd_ok  = 1'b0;
        endcase
    end

    assign op_ok = (op == OP_MEM) || (op == OP_BR) || ((op == OP_DP) && cmd_ok);

    always_comb begin
        next_state   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_pc       = 1'b0;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        alu_src_imm  = 1'b0;
        alu_ctrl     = ALU_ADD;
        flags_write  = 1'b0;
        data_write   = 1'b0;
        reg_write    = 1'b0;
        reg_src_data = 1'b0;
        pc_write_alu = 1'b0;
        pc_branch    = 1'b0;
        case (state)
            RST: next_state = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                adr_pc  = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                ab_write = 1'b1;
                if (!cond_ok || !op_ok) next_state = FETCH;
                else if (op == OP_MEM)  next_state = MEMADR;
                else if (op == OP_BR)   next_state = BRANCH;
                else                    next_state = funct[5] ? EXECI : EXECR;
            end
            MEMADR: begin
                aluout_write = 1'b1;
                alu_src_imm  = 1'b1;
                next_state   = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    data_write = 1'b1;
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                reg_write    = 1'b1;
                reg_src_data = 1'b1;
                next_state   = FETCH;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXECR, EXECI: begin
                aluout_write = 1'b1;
                alu_src_imm  = (state == EXECI);
                alu_ctrl     = dp_ctrl;
                flags_write  = funct[0];
                next_state   = ALUWB;
            end
            ALUWB: begin
                reg_write    = 1'b1;
                pc_write_alu = (rd == 4'hF);
                next_state   = FETCH;
            end
            BRANCH: begin
                pc_branch  = 1'b1;
                next_state = FETCH;
            end
            default: next_state = RST;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: rtl/regfileDB.sv
// R0-R14 register file with two read ports, one write port and a debug read port.
// R15 is not stored: reads return the caller-supplied PC-relative values.
module regfileDB (
    input  logic        clk,
    input  logic        reset,
    input  logic        we3,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [3:0]  wa3,
    input  logic [31:0] wd3,
    input  logic [31:0] r15,
    input  logic [31:0] r15_db,
    input  logic [3:0]  DBtheReg,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] DBtheRegVal
);

    logic [31:0] rf [0:15];

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: this array is reset explicitly because software relies on registers reading zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (we3 && (wa3 != 4'hF)) begin
            rf[wa3] <= wd3;
        end
    end

    assign rd1         = (ra1 == 4'hF)      ? r15    : rf[ra1];
    assign rd2         = (ra2 == 4'hF)      ? r15    : rf[ra2];
    assign DBtheRegVal = (DBtheReg == 4'hF) ? r15_db : rf[DBtheReg];

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle ARM-subset core on a single req/ready memory port with
// conditional execution, configurable reset vector and address width.
module multicycle_processor
    import mc_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic [3:0]        DBtheReg,
    output logic [31:0]       DBtheRegVal,
    output logic [31:0]       machineValue,
    output logic [3:0]        state_dbg
);

    logic [31:0] pc, ir, a_reg, b_reg, alu_out, data_reg;
    logic [3:0]  flags;

    logic        adr_pc, ir_write, ab_write, aluout_write, alu_src_imm;
    logic        flags_write, data_write, reg_write, reg_src_data;
    logic        pc_write_alu, pc_branch;
    logic [1:0]  alu_ctrl;

    logic [31:0] rd1, rd2, ext_imm, alu_b, alu_result, addr_full;
    logic [3:0]  alu_flags, ra2;

    mc_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .cond         (ir[31:28]),
        .op           (ir[27:26]),
        .funct        (ir[25:20]),
        .rd           (ir[15:12]),
        .flags        (flags),
        .mem_ready    (mem_ready),
        .state_dbg    (state_dbg),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .adr_pc       (adr_pc),
        .ir_write     (ir_write),
        .ab_write     (ab_write),
        .aluout_write (aluout_write),
        .alu_src_imm  (alu_src_imm),
        .alu_ctrl     (alu_ctrl),
        .flags_write  (flags_write),
        .data_write   (data_write),
        .reg_write    (reg_write),
        .reg_src_data (reg_src_data),
        .pc_write_alu (pc_write_alu),
        .pc_branch    (pc_branch)
    );

    // Stores read Rd on the second port; data-processing reads Rm.
    assign ra2 = (ir[27:26] == OP_MEM) ? ir[15:12] : ir[3:0];

    // PC already points at instr+4 after fetch, so R15 as an operand is PC+4.
    regfileDB u_rf (
        .clk         (clk),
        .reset       (reset),
        .we3         (reg_write),
        .ra1         (ir[19:16]),
        .ra2         (ra2),
        .wa3         (ir[15:12]),
        .wd3         (reg_src_data ? data_reg : alu_out),
        .r15         (pc + 32'd4),
        .r15_db      (pc + 32'd8),
        .DBtheReg    (DBtheReg),
        .rd1         (rd1),
        .rd2         (rd2),
        .DBtheRegVal (DBtheRegVal)
    );

    extend u_ext (
        .instr   (ir[23:0]),
        .imm_src (ir[27:26]),
        .ext_imm (ext_imm)
    );

    assign alu_b = alu_src_imm ? ext_imm : b_reg;

    alu u_alu (
        .a        (a_reg),
        .b        (alu_b),
        .alu_ctrl (alu_ctrl),
        .result   (alu_result),
        .flags    (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            data_reg <= '0;
            flags    <= '0;
        end else begin
            if (ir_write)          pc <= pc + 32'd4;
            else if (pc_branch)    pc <= pc + 32'd4 + ext_imm;
            else if (pc_write_alu) pc <= alu_out;
            if (ir_write)     ir       <= mem_rdata;
            if (ab_write)     a_reg    <= rd1;
            if (ab_write)     b_reg    <= rd2;
            if (aluout_write) alu_out  <= alu_result;
            if (data_write)   data_reg <= mem_rdata;
            if (flags_write)  flags    <= alu_flags;
        end
    end

    // Address sources hold still across wait states: PC and ALUOut only change on completion.
    assign addr_full    = adr_pc ? pc : alu_out;
    assign mem_addr     = addr_full[ADDR_W-1:0];
    assign mem_wdata    = b_reg;
    assign machineValue = ir;

endmodule
